// File: rtl/minirisc_seq_if.sv
// minirisc_seq bus: program-store write port, run handshake
// and accumulator/output observation signals.
interface minirisc_seq_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] acc_out;
  logic       out_valid;
  logic [7:0] out_data;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  busy, done, err, acc_out,
    input  out_valid, out_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output busy, done, err, acc_out,
    output out_valid, out_data
  );
endinterface

// File: rtl/minirisc_seq.sv
// minirisc_seq: microprogram sequencer running a 16-word
// program store against an 8-bit accumulator.
module minirisc_seq #(
  parameter int PROG_DEPTH = 16,
  parameter int MAX_STEPS  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  minirisc_seq_if.slave bus
);
  localparam logic [7:0] MAX_S = MAX_STEPS[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUBI = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_JNZ  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] steps_q, steps_d;
  logic [7:0] ir_q, ir_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ov_q, ov_d;
  logic [7:0] od_q, od_d;
  logic [7:0] mem_q [PROG_DEPTH];
  logic [7:0] mem_d [PROG_DEPTH];

  logic [2:0] op;
  logic [7:0] imm;
  logic       is_halt;
  logic       last_step;

  assign op        = ir_q[7:5];
  assign imm       = {3'b000, ir_q[4:0]};
  assign is_halt   = (op == OP_HALT);
  assign last_step = ((steps_q + 8'd1) == MAX_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      steps_q <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      for (int i = 0; i < PROG_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      steps_q <= steps_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      for (int i = 0; i < PROG_DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE:
          if (bus.start) state_d = S_FETCH;
        S_FETCH:
          state_d = S_EXEC;
        S_EXEC:
          if (is_halt || last_step)
            state_d = S_IDLE;
          else
            state_d = S_FETCH;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // Pulses default low so they self-clear even with ena=0.
  always_comb begin
    pc_d    = pc_q;
    acc_d   = acc_q;
    steps_d = steps_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    mem_d   = mem_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.prog_we)
            mem_d[bus.prog_addr] = bus.prog_data;
          if (bus.start) begin
            pc_d    = '0;
            steps_d = '0;
            err_d   = 1'b0;
          end
        end
        S_FETCH:
          ir_d = mem_q[pc_q];
        S_EXEC: begin
          steps_d = steps_q + 8'd1;
          pc_d    = pc_q + 4'd1;
          unique case (op)
            OP_NOP:  ;
            OP_LDI:  acc_d = imm;
            OP_ADDI: acc_d = acc_q + imm;
            OP_SUBI: acc_d = acc_q - imm;
            OP_OUT: begin
              od_d = acc_q;
              ov_d = 1'b1;
            end
            OP_JNZ:
              if (acc_q != 8'd0) pc_d = imm[3:0];
            OP_SHL:  acc_d = {acc_q[6:0], 1'b0};
            OP_HALT: done_d = 1'b1;
            default: ;
          endcase
          if (!is_halt && last_step) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
endmodule

// File: tb/tb_minirisc_seq.sv
// Testbench for minirisc_seq: ISA-level reference model with
// per-cycle comparison of every observable output.
module tb_minirisc_seq;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  always #5 clk = ~clk;

  minirisc_seq_if bus();

  minirisc_seq dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_prog [16];
  logic [7:0] m_acc;
  logic [7:0] m_out;
  logic       m_err;

  logic [7:0] t_acc [256];
  logic [7:0] t_od  [256];
  bit         t_out [256];
  int         t_n;
  bit         t_abort;

  task automatic chk(input string name,
                     input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, got, exp);
    end
  endtask

  // Instruction-level execution of the current program.
  function automatic void isa_model();
    logic [3:0] pc;
    logic [7:0] acc, od, ir, imm;
    pc = 4'd0;
    acc = m_acc;
    od = m_out;
    t_acc[0] = acc;
    t_od[0] = od;
    t_out[0] = 1'b0;
    t_n = 255;
    t_abort = 1'b1;
    for (int c = 1; c <= 255; c++) begin
      ir = m_prog[pc];
      imm = {3'b000, ir[4:0]};
      t_out[c] = 1'b0;
      pc = pc + 4'd1;
      case (ir[7:5])
        3'd1: acc = imm;
        3'd2: acc = acc + imm;
        3'd3: acc = acc - imm;
        3'd4: begin od = acc; t_out[c] = 1'b1; end
        3'd5: if (acc != 0) pc = ir[3:0];
        3'd6: acc = acc << 1;
        default: ;
      endcase
      t_acc[c] = acc;
      t_od[c] = od;
      if (ir[7:5] == 3'd7) begin
        t_n = c;
        t_abort = 1'b0;
        break;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_prog[i] = 8'h00;
    m_acc = 8'h00;
    m_out = 8'h00;
    m_err = 1'b0;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, m_err);
    chk({tag, "_ov"}, bus.out_valid, 0);
    chk({tag, "_acc"}, bus.acc_out, m_acc);
    chk({tag, "_od"}, bus.out_data, m_out);
  endtask

  task automatic load(input logic [7:0] w [16]);
    for (int a = 0; a < 16; a++) begin
      bus.prog_we = 1'b1;
      bus.prog_addr = 4'(a);
      bus.prog_data = w[a];
      m_prog[a] = w[a];
      @(posedge clk);
      @(negedge clk);
    end
    bus.prog_we = 1'b0;
  endtask

  // Edge index e counts enabled edges; e=0 is the start edge.
  task automatic run_prog(input int gap_at, input int gap_len,
                          input bit intrude,
                          output int done_edge);
    int e, gap_left, c, n2;
    bit last_en;
    isa_model();
    n2 = 2 * t_n;
    e = -1;
    gap_left = 0;
    done_edge = -1;
    bus.start = 1'b1;
    ena = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      last_en = ena;
      if (ena) e++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.prog_we = 1'b0;
      c = (e / 2 < t_n) ? e / 2 : t_n;
      chk("busy", bus.busy, int'(e < n2));
      chk("done", bus.done, int'(last_en && e == n2));
      chk("out_valid", bus.out_valid,
          int'(last_en && e >= 2 && e % 2 == 0 &&
               t_out[e / 2]));
      chk("acc_out", bus.acc_out, t_acc[c]);
      chk("out_data", bus.out_data, t_od[c]);
      chk("err", bus.err, (e >= n2) ? int'(t_abort) : 0);
      if (last_en && e == n2) begin
        done_edge = cyc + 1;
        break;
      end
      ena = 1'b1;
      if (last_en && e == gap_at && gap_len > 0)
        gap_left = gap_len;
      if (gap_left > 0) begin
        ena = 1'b0;
        gap_left--;
      end
      if (intrude && last_en && e == 3) begin
        bus.start = 1'b1;
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'($urandom_range(0, 15));
        bus.prog_data = 8'($urandom);
      end
    end
    if (done_edge < 0) chk("run_timeout", 1, 0);
    ena = 1'b1;
    m_acc = t_acc[t_n];
    m_out = t_od[t_n];
    m_err = t_abort;
  endtask

  logic [7:0] pg [16];
  int de;

  task automatic set_pg(input logic [7:0] a, b, c, d,
                        e, f, g);
    for (int i = 0; i < 16; i++) pg[i] = 8'h00;
    pg[0] = a; pg[1] = b; pg[2] = c; pg[3] = d;
    pg[4] = e; pg[5] = f; pg[6] = g;
  endtask

  initial begin
    ena = 1'b1;
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = 4'd0;
    bus.prog_data = 8'd0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'($urandom);
      bus.prog_we = 1'($urandom);
      bus.prog_addr = 4'($urandom);
      bus.prog_data = 8'($urandom);
      ena = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    ena = 1'b1;
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    model_reset();
    idle_chk("reset");

    run_prog(-1, 0, 1'b0, de);
    chk("empty_n", t_n, 255);
    chk("empty_done_edge", de, 511);
    chk("empty_err", bus.err, 1);

    set_pg(8'h25, 8'h43, 8'h80, 8'hE0, 0, 0, 0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("basic_done_edge", de, 9);
    chk("basic_acc", bus.acc_out, 8'h08);
    chk("basic_od", bus.out_data, 8'h08);
    chk("basic_err", bus.err, 0);

    set_pg(8'h23, 8'h61, 8'hA1, 8'hE0, 0, 0, 0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("loop_n", t_n, 8);
    chk("loop_done_edge", de, 17);
    chk("loop_acc", bus.acc_out, 8'h00);

    set_pg(8'h3F, 8'hC0, 8'hC0, 8'hC0, 8'h4A, 8'h80, 8'hE0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("wrap_od", bus.out_data, 8'h02);

    set_pg(8'h20, 8'h61, 8'hE0, 0, 0, 0, 0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("wrap_sub_acc", bus.acc_out, 8'hFF);

    set_pg(8'h21, 8'hA1, 0, 0, 0, 0, 0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("runaway_done_edge", de, 511);
    chk("runaway_err", bus.err, 1);

    set_pg(8'h25, 8'h43, 8'h80, 8'hE0, 0, 0, 0);
    load(pg);
    run_prog(-1, 0, 1'b0, de);
    chk("err_cleared", bus.err, 0);

    run_prog(-1, 0, 1'b1, de);
    chk("intrude_done_edge", de, 9);
    run_prog(-1, 0, 1'b0, de);
    chk("intrude_prog_kept", de, 9);

    run_prog(3, 5, 1'b0, de);
    chk("ena_gap_done_edge", de, 14);

    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      idle_chk("midrst");
      @(posedge clk);
      @(negedge clk);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) pg[i] = 8'($urandom);
      load(pg);
      run_prog($urandom_range(0, 12), $urandom_range(0, 6),
               1'($urandom), de);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
